// File: rtl/ejtag_dint_req.sv
// ---------------------------------------------------------------------------
// ejtag_dint_req
// Debug-interrupt request controller. Sits behind the two-flop synchronizers
// and merges two request sources into one level request to the core:
//   - a JTAG request toggle from the TCK domain (each level change = 1 request)
//   - an external debug-interrupt pin, debounced by a saturating filter
// The request is held until the core acknowledges it. The block then waits for
// the core to leave debug mode before it accepts a new request. Each JTAG
// request that is consumed is answered with one change of the ack toggle.
//
// Ports
//   CLK           in  core clock, posedge
//   RESET_N       in  asynchronous active-low reset
//   REQ_TOG_SYNC  in  synchronized JTAG request toggle
//   DINT_PIN      in  synchronized external debug-interrupt pin (level)
//   CORE_ACK      in  one-cycle pulse, core took the debug exception
//   DEBUG_MODE    in  core is in debug mode
//   STATUS_CLR    in  one-cycle pulse, clears OVERRUN and TIMEOUT_ERR
//   DINT_REQ      out debug-interrupt request to the core (level)
//   ACK_TOG       out ack toggle back to the TCK domain
//   SRC_JTAG      out current/last serviced request came from JTAG (0 = pin)
//   OVERRUN       out sticky, a request arrived while one was pending
//   TIMEOUT_ERR   out sticky, request pending TIMEOUT cycles without ack
// ---------------------------------------------------------------------------
module ejtag_dint_req #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned FILT_W   = 3,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned TO_W     = 10
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic REQ_TOG_SYNC,
  input  logic DINT_PIN,
  input  logic CORE_ACK,
  input  logic DEBUG_MODE,
  input  logic STATUS_CLR,
  output logic DINT_REQ,
  output logic ACK_TOG,
  output logic SRC_JTAG,
  output logic OVERRUN,
  output logic TIMEOUT_ERR
);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILT_LEN);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              tog_q, tog_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [TO_W-1:0]   toc_q, toc_d;
  logic              svc_wait_q, svc_wait_d;
  logic              dint_req_q, dint_req_d;
  logic              ack_tog_q, ack_tog_d;
  logic              src_jtag_q, src_jtag_d;
  logic              overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;

  logic jtag_evt;
  logic pin_evt;
  logic evt;
  logic overrun_set;
  logic timeout_set;

  // Request detection: toggle edge from JTAG, filtered rising run from the pin
  always_comb begin
    tog_d    = REQ_TOG_SYNC;
    jtag_evt = REQ_TOG_SYNC ^ tog_q;
    // The pin fires on the sample that completes FILT_LEN highs; the counter
    // then saturates one above, so a long high period fires only once.
    pin_evt  = DINT_PIN & (filt_cnt_q == FILT_LAST);
    evt      = jtag_evt | pin_evt;
  end

  // Pin filter counter: clear on low, count highs, saturate at FILT_LEN
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (!DINT_PIN) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q < FILT_MAX) begin
      filt_cnt_d = filt_cnt_q + FILT_W'(1);
    end else begin
      filt_cnt_d = filt_cnt_q;
    end
  end

  // Request FSM next state, timeout counter, ack toggle and source tracking
  always_comb begin
    state_d     = state_q;
    toc_d       = '0;
    svc_wait_d  = 1'b0;
    ack_tog_d   = ack_tog_q;
    src_jtag_d  = src_jtag_q;
    overrun_set = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          if (!DEBUG_MODE) begin
            state_d    = ST_PEND;
            src_jtag_d = jtag_evt;
          end else begin
            // Request dropped while the core is already in debug mode;
            // a JTAG requester still gets its answer.
            ack_tog_d = ack_tog_q ^ jtag_evt;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PEND: begin
        // Count up to TIMEOUT and hold there, so the error flag is only set
        // once per pending period and STATUS_CLR can clear it.
        if (toc_q < TO_MAX) begin
          toc_d = toc_q + TO_W'(1);
        end else begin
          toc_d = toc_q;
        end
        overrun_set = evt;
        // A JTAG request merged into a pin request must still be answered.
        if (jtag_evt) begin
          src_jtag_d = 1'b1;
        end else begin
          src_jtag_d = src_jtag_q;
        end
        if (CORE_ACK) begin
          state_d    = ST_SERVICE;
          toc_d      = '0;
          svc_wait_d = 1'b1;
          ack_tog_d  = ack_tog_q ^ (src_jtag_q | jtag_evt);
        end else if (toc_q == TO_LAST) begin
          timeout_set = 1'b1;
        end else begin
          timeout_set = 1'b0;
        end
      end

      ST_SERVICE: begin
        ack_tog_d = ack_tog_q ^ jtag_evt;
        // Skip the first service cycle so the core has time to raise
        // DEBUG_MODE before its absence is taken as debug exit.
        if (!svc_wait_q && !DEBUG_MODE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dint_req_d    = (state_d == ST_PEND);
    // A flag set in the same cycle as STATUS_CLR wins over the clear.
    overrun_d     = overrun_set | (overrun_q & ~STATUS_CLR);
    timeout_err_d = timeout_set | (timeout_err_q & ~STATUS_CLR);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      tog_q         <= 1'b0;
      filt_cnt_q    <= '0;
      toc_q         <= '0;
      svc_wait_q    <= 1'b0;
      dint_req_q    <= 1'b0;
      ack_tog_q     <= 1'b0;
      src_jtag_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tog_q         <= tog_d;
      filt_cnt_q    <= filt_cnt_d;
      toc_q         <= toc_d;
      svc_wait_q    <= svc_wait_d;
      dint_req_q    <= dint_req_d;
      ack_tog_q     <= ack_tog_d;
      src_jtag_q    <= src_jtag_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign DINT_REQ    = dint_req_q;
  assign ACK_TOG     = ack_tog_q;
  assign SRC_JTAG    = src_jtag_q;
  assign OVERRUN     = overrun_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_ejtag_dint_req.sv
// ---------------------------------------------------------------------------
// tb_ejtag_dint_req
// Directed bench for ejtag_dint_req. A transaction-level model tracks whether
// a request is pending or in service, run lengths and ages as plain integers,
// and is compared with the DUT outputs on every falling edge. Literal checks at
// key points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_ejtag_dint_req;

  localparam int FILT_LEN = 4;
  localparam int FILT_W   = 3;
  localparam int TIMEOUT  = 16;
  localparam int TO_W     = 5;

  logic clk;
  logic rst_n;
  logic req_tog;
  logic dint_pin;
  logic core_ack;
  logic debug_mode;
  logic status_clr;
  logic dint_req;
  logic ack_tog;
  logic src_jtag;
  logic overrun;
  logic timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  bit done    = 1'b0;

  ejtag_dint_req #(
    .FILT_LEN(FILT_LEN),
    .FILT_W  (FILT_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .REQ_TOG_SYNC(req_tog),
    .DINT_PIN    (dint_pin),
    .CORE_ACK    (core_ack),
    .DEBUG_MODE  (debug_mode),
    .STATUS_CLR  (status_clr),
    .DINT_REQ    (dint_req),
    .ACK_TOG     (ack_tog),
    .SRC_JTAG    (src_jtag),
    .OVERRUN     (overrun),
    .TIMEOUT_ERR (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model view of the controller
  typedef struct packed {
    bit pending;
    bit in_service;
    int svc_age;
    int pend_age;
    bit src;
    bit ack;
    bit ovr;
    bit tout;
    bit prev_tog;
    int pin_run;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t s, bit tog, bit pin, bit ack_in,
                                         bit dm, bit clr);
    mstate_t n;
    bit jev, pev, ovr_set, to_set;
    n       = s;
    jev     = (tog != s.prev_tog);
    pev     = pin && (s.pin_run == FILT_LEN - 1);
    ovr_set = 1'b0;
    to_set  = 1'b0;
    n.prev_tog = tog;
    n.pin_run  = pin ? s.pin_run + 1 : 0;
    if (s.pending) begin
      n.pend_age = s.pend_age + 1;
      ovr_set    = jev || pev;
      if (jev) n.src = 1'b1;
      if (ack_in) begin
        n.pending    = 1'b0;
        n.in_service = 1'b1;
        n.svc_age    = 0;
        if (s.src || jev) n.ack = ~s.ack;
      end else if (s.pend_age == TIMEOUT - 1) begin
        to_set = 1'b1;
      end
    end else if (s.in_service) begin
      if (jev) n.ack = ~s.ack;
      n.svc_age = s.svc_age + 1;
      if (s.svc_age >= 1 && !dm) n.in_service = 1'b0;
    end else if (jev || pev) begin
      if (!dm) begin
        n.pending  = 1'b1;
        n.pend_age = 0;
        n.src      = jev;
      end else if (jev) begin
        n.ack = ~s.ack;
      end
    end
    n.ovr  = ovr_set | (s.ovr & !clr);
    n.tout = to_set | (s.tout & !clr);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, req_tog, dint_pin, core_ack, debug_mode, status_clr);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [4:0] act, exp_v;
    if (!done) begin
      act   = {dint_req, ack_tog, src_jtag, overrun, timeout_err};
      exp_v = {m.pending, m.ack, m.src, m.ovr, m.tout};
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL model_cmp t=%0t got %b expected %b (dint,ack,src,ovr,tout)",
                    $time, act, exp_v);
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp_v);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dint"}, dint_req, 1'b0);
    chk({nm, "_ack"},  ack_tog, 1'b0);
    chk({nm, "_src"},  src_jtag, 1'b0);
    chk({nm, "_ovr"},  overrun, 1'b0);
    chk({nm, "_tout"}, timeout_err, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_tog    = 1'b0;
    dint_pin   = 1'b0;
    core_ack   = 1'b0;
    debug_mode = 1'b0;
    status_clr = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk_all_zero("reset");

    // JTAG request, ack, debug-mode service, JTAG toggle during service
    req_tog = 1'b1; step(1);
    chk("jtag_req_dint", dint_req, 1'b1);
    chk("jtag_req_src", src_jtag, 1'b1);
    chk("jtag_req_ack", ack_tog, 1'b0);
    step(3);
    core_ack = 1'b1; step(1);
    core_ack = 1'b0; debug_mode = 1'b1;
    chk("jtag_ack_dint", dint_req, 1'b0);
    chk("jtag_ack_tog", ack_tog, 1'b1);
    step(4);
    req_tog = 1'b0; step(1);
    chk("svc_drop_ack", ack_tog, 1'b0);
    chk("svc_drop_dint", dint_req, 1'b0);
    chk("svc_drop_ovr", overrun, 1'b0);
    step(5);
    debug_mode = 1'b0; step(3);

    // Pin filter: 3 highs too short, 4 highs make a request
    dint_pin = 1'b1; step(3);
    dint_pin = 1'b0; step(1);
    chk("pin3_no_req", dint_req, 1'b0);
    dint_pin = 1'b1; step(4);
    chk("pin4_dint", dint_req, 1'b1);
    chk("pin4_src", src_jtag, 1'b0);
    chk("pin4_ack", ack_tog, 1'b0);
    step(3);
    chk("pin_hold_no_ovr", overrun, 1'b0);
    dint_pin = 1'b0; step(1);

    // JTAG merged into pending pin request
    req_tog = 1'b1; step(1);
    chk("merge_ovr", overrun, 1'b1);
    chk("merge_src", src_jtag, 1'b1);
    chk("merge_dint", dint_req, 1'b1);
    core_ack = 1'b1; step(1);
    core_ack = 1'b0;
    chk("merge_ack_dint", dint_req, 1'b0);
    chk("merge_ack_tog", ack_tog, 1'b1);
    step(3);
    chk("merge_ack_once", ack_tog, 1'b1);
    status_clr = 1'b1; step(1);
    status_clr = 1'b0;
    chk("clr_ovr", overrun, 1'b0);

    // New JTAG request, then protocol-violating toggle with STATUS_CLR
    req_tog = 1'b0; step(1);
    chk("req2_dint", dint_req, 1'b1);
    req_tog = 1'b1; status_clr = 1'b1; step(1);
    status_clr = 1'b0;
    chk("set_beats_clr", overrun, 1'b1);
    chk("violation_no_ack", ack_tog, 1'b1);
    core_ack = 1'b1; step(1);
    core_ack = 1'b0;
    chk("req2_ack_tog", ack_tog, 1'b0);
    chk("req2_ack_dint", dint_req, 1'b0);
    step(3);

    // Timeout while pending
    req_tog = 1'b0; step(1);
    chk("to_dint", dint_req, 1'b1);
    step(15);
    chk("to_before", timeout_err, 1'b0);
    step(1);
    chk("to_set", timeout_err, 1'b1);
    chk("to_dint_held", dint_req, 1'b1);
    status_clr = 1'b1; step(1);
    status_clr = 1'b0;
    chk("to_clr", timeout_err, 1'b0);
    step(5);
    chk("to_stays_clr", timeout_err, 1'b0);
    chk("to_still_pend", dint_req, 1'b1);

    // Async reset while pending
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dint", dint_req, 1'b0);
    step(2);
    #3;
    rst_n = 1'b1;
    step(3);
    chk_all_zero("post_rst");

    // JTAG toggle in IDLE while already in debug mode
    debug_mode = 1'b1; req_tog = 1'b1; step(1);
    chk("dm_drop_dint", dint_req, 1'b0);
    chk("dm_drop_ack", ack_tog, 1'b1);
    step(2);
    debug_mode = 1'b0; step(2);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
